traffic_light_monitor: RTL and testbench
========================================

Name: traffic_light_monitor

Overview:
- Passive checker on the six lamp outputs of the NS/EW traffic-light controller; it reads the lamps the controller drives.
- Decodes lamps into a phase and tracks phase order NS_G→NS_Y→EW_G→EW_Y→NS_G.
- Counts ticks per phase and flags illegal lamp combinations, out-of-order phases and wrong phase durations.
- Used in the system bench and as an optional on-chip safety monitor; never drives the lamps.

Parameters:
- NS_G_TICKS, 5, expected NS green duration in ticks (>=1)
- NS_Y_TICKS, 2, expected NS yellow duration in ticks (>=1)
- EW_G_TICKS, 5, expected EW green duration in ticks (>=1)
- EW_Y_TICKS, 2, expected EW yellow duration in ticks (>=1)
- CW, 16, width of the rotation counter
- ECW, 8, width of the error counter

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous active-high reset
- tick  in  1  same 1-cycle tick pulse the controller uses
- ns_g, ns_y, ns_r  in  1 each  NS lamps under observation
- ew_g, ew_y, ew_r  in  1 each  EW lamps under observation
- clr_err  in  1  synchronous clear of err_sticky and err_count
- phase  out  2  last decoded legal phase (00 NS_G, 01 NS_Y, 10 EW_G, 11 EW_Y)
- locked  out  1  monitor is in TRACK
- err  out  1  one-cycle error pulse
- err_code  out  3  code of the most recent error, held
- err_sticky  out  4  OR of error bits [0]=ILLEGAL [1]=ORDER [2]=SHORT [3]=LONG
- err_count  out  ECW  saturating error count
- rot_count  out  CW  completed rotations, wraps

Behaviour:
- Interface decided: one clock; reset asynchronous, active-high, ports clk/rst.
- All outputs registered. Reset values: phase=00, locked=0, err=0, err_code=0, err_sticky=0, err_count=0, rot_count=0, tick_cnt=0, state SYNC.
- Decode (combinational, current cycle) accepts only four legal patterns:
  - NS_G = ns_g & ew_r
  - NS_Y = ns_y & ew_r
  - EW_G = ew_g & ns_r
  - EW_Y = ew_y & ns_r
  - Each pattern requires exactly one lamp per road. Any other pattern is ILLEGAL.
- Expected duration N(phase) is selected from the parameters.
- States:
  - SYNC: on the first legal decode, load phase, tick_cnt=0 and a partial flag → TRACK. An ILLEGAL decode in SYNC is ignored; lamps may be X/settling out of reset.
  - TRACK, decode equals phase: if tick, tick_cnt+=1. If tick while tick_cnt==N and LONG not yet flagged for this phase → error LONG (code 4); tick_cnt saturates at N+1.
  - TRACK, decode is the legal successor:
    - If !partial and tick_cnt!=N → SHORT (code 3) when tick_cnt<N. The tick_cnt>N case was already flagged LONG.
    - Then load the new phase, tick_cnt=0 (or 1 if tick this cycle), clear partial.
    - EW_Y→NS_G increments rot_count, wrapping mod 2^CW.
  - TRACK, decode legal but not the successor (includes a same-cycle jump) → ORDER (code 2). Lock onto the new phase with partial=1; duration is not checked.
  - TRACK, decode ILLEGAL → ILLEGAL (code 1), go to SYNC, locked=0.
- Timing: the controller changes lamps on the edge of the Nth tick. The monitor samples that tick in the old phase (tick_cnt=N) and sees the new phase the following cycle, so an exact-N phase passes.
- Error reporting:
  - Detection at edge k sets err=1 during cycle k+1, with err_code updated, the sticky bit ORed in and err_count +1 (saturating at 2^ECW-1).
  - At most one error per cycle. Priority: ILLEGAL > ORDER > SHORT > LONG.
- clr_err takes effect at the edge. If an error is detected in the same cycle, the error wins: sticky holds that bit only, count=1. err_code is not cleared.
- Reset asserted mid-phase returns immediately to the reset values and SYNC.

Decomposition:
- Package traffic_pkg: phase encodings (shared with the controller: NS_G=00, NS_Y=01, EW_G=10, EW_Y=11), a next-phase function, error codes (NONE=0, ILLEGAL=1, ORDER=2, SHORT=3, LONG=4) and sticky bit indices.
- One sub-module, traffic_lamp_decode: six lamps in → legal bit + 2-bit phase out, purely combinational.
- Top holds the FSM, tick counter, error and rotation counters.

Test Plan:
- Drive the real controller with default parameters and a tick every 4 cycles for 3 full rotations (42 ticks) → locked=1 after the first cycle out of reset, err never 1, rot_count=3, err_sticky=0.
- Force NS_G→NS_Y after 4 ticks → one err pulse, err_code=3, err_sticky=0100, err_count=1; monitor continues in NS_Y with no further errors.
- Hold NS_G for 7 ticks → err pulse once on the 6th tick, err_code=4; no further pulse on the 7th; the later NS_Y transition gives no SHORT.
- Jump NS_G directly to EW_G → err_code=2. The following EW_G with 3 ticks is not flagged (partial); the next EW_Y with 1 tick gives err_code=3.
- Drive ns_g=1, ew_g=1 for one cycle → err_code=1, locked=0 the next cycle; relock on the next legal NS_G. Assert clr_err → err_sticky=0, err_count=0.
- Assert rst asynchronously mid-EW_G with err_count=5 → all outputs reset immediately without a clock edge; after release, locked=1 on the first legal decode.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared traffic-light types: lamp phase encodings, monitor state,
// error codes, sticky-bit indices and small helper functions.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_NS_G = 2'b00,
    PH_NS_Y = 2'b01,
    PH_EW_G = 2'b10,
    PH_EW_Y = 2'b11
  } phase_t;

  typedef enum logic {
    ST_SYNC  = 1'b0,
    ST_TRACK = 1'b1
  } mon_state_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_ILLEGAL = 3'd1,
    ERR_ORDER   = 3'd2,
    ERR_SHORT   = 3'd3,
    ERR_LONG    = 3'd4
  } err_code_t;

  localparam int STK_ILLEGAL = 0;
  localparam int STK_ORDER   = 1;
  localparam int STK_SHORT   = 2;
  localparam int STK_LONG    = 3;

  // Rotation order NS_G -> NS_Y -> EW_G -> EW_Y -> NS_G
  // is just the encoding plus one, wrapping.
  function automatic phase_t next_phase(phase_t p);
    return phase_t'(p + 2'd1);
  endfunction

  function automatic logic [3:0] err_bits(err_code_t c);
    logic [3:0] b;
    b = '0;
    case (c)
      ERR_ILLEGAL: b[STK_ILLEGAL] = 1'b1;
      ERR_ORDER:   b[STK_ORDER]   = 1'b1;
      ERR_SHORT:   b[STK_SHORT]   = 1'b1;
      ERR_LONG:    b[STK_LONG]    = 1'b1;
      default:     b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/traffic_lamp_decode.sv
// Combinational lamp decoder: maps the six observed lamps to one of the
// four legal phases.
// Ports: ns_g/ns_y/ns_r, ew_g/ew_y/ew_r in; legal, phase out.
module traffic_lamp_decode
  import traffic_pkg::*;
(
  input  logic   ns_g,
  input  logic   ns_y,
  input  logic   ns_r,
  input  logic   ew_g,
  input  logic   ew_y,
  input  logic   ew_r,
  output logic   legal,
  output phase_t phase
);

  logic [5:0] lamps;

  assign lamps = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r};

  // Whole-vector matches enforce exactly one lamp per road.
  always_comb begin
    legal = 1'b1;
    phase = PH_NS_G;
    unique case (1'b1)
      (lamps == 6'b100_001): phase = PH_NS_G;
      (lamps == 6'b010_001): phase = PH_NS_Y;
      (lamps == 6'b001_100): phase = PH_EW_G;
      (lamps == 6'b001_010): phase = PH_EW_Y;
      default:               legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive safety monitor for the NS/EW traffic-light controller lamps.
// Ports: clk, rst (async high), tick, six lamps, clr_err in;
//   phase, locked, err, err_code, err_sticky, err_count, rot_count out.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int NS_G_TICKS = 5,
  parameter int NS_Y_TICKS = 2,
  parameter int EW_G_TICKS = 5,
  parameter int EW_Y_TICKS = 2,
  parameter int CW         = 16,
  parameter int ECW        = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic           ns_g,
  input  logic           ns_y,
  input  logic           ns_r,
  input  logic           ew_g,
  input  logic           ew_y,
  input  logic           ew_r,
  input  logic           clr_err,
  output logic [1:0]     phase,
  output logic           locked,
  output logic           err,
  output logic [2:0]     err_code,
  output logic [3:0]     err_sticky,
  output logic [ECW-1:0] err_count,
  output logic [CW-1:0]  rot_count
);

  localparam int NMAX_A = (NS_G_TICKS > NS_Y_TICKS) ? NS_G_TICKS : NS_Y_TICKS;
  localparam int NMAX_B = (EW_G_TICKS > EW_Y_TICKS) ? EW_G_TICKS : EW_Y_TICKS;
  localparam int NMAX   = (NMAX_A > NMAX_B) ? NMAX_A : NMAX_B;
  // Counter must hold the saturation value N+1.
  localparam int TW     = $clog2(NMAX + 2);

  function automatic logic [TW-1:0] dur(phase_t p);
    logic [TW-1:0] n;
    unique case (p)
      PH_NS_G: n = TW'(NS_G_TICKS);
      PH_NS_Y: n = TW'(NS_Y_TICKS);
      PH_EW_G: n = TW'(EW_G_TICKS);
      default: n = TW'(EW_Y_TICKS);
    endcase
    return n;
  endfunction

  logic          dec_legal;
  phase_t        dec_phase;
  mon_state_t    state;
  phase_t        phase_q;
  logic [TW-1:0] tick_cnt;
  logic          partial;
  logic [TW-1:0] n_cur;
  err_code_t     det_code;
  logic          det;
  logic          is_succ;
  logic [3:0]    det_bits;

  traffic_lamp_decode u_dec (
    .ns_g  (ns_g),
    .ns_y  (ns_y),
    .ns_r  (ns_r),
    .ew_g  (ew_g),
    .ew_y  (ew_y),
    .ew_r  (ew_r),
    .legal (dec_legal),
    .phase (dec_phase)
  );

  assign phase = phase_q;

  // Error detection for this cycle; branches are mutually exclusive,
  // which gives ILLEGAL > ORDER > SHORT > LONG for free.
  always_comb begin
    n_cur    = dur(phase_q);
    is_succ  = (dec_phase == next_phase(phase_q));
    det_code = ERR_NONE;
    if (state == ST_TRACK) begin
      if (!dec_legal) begin
        det_code = ERR_ILLEGAL;
      end else if (dec_phase == phase_q) begin
        // tick_cnt saturates at N+1, so this hits once per phase.
        if (tick && !partial && tick_cnt == n_cur)
          det_code = ERR_LONG;
      end else if (is_succ) begin
        // Overlong phases were already flagged as LONG.
        if (!partial && tick_cnt < n_cur)
          det_code = ERR_SHORT;
      end else begin
        det_code = ERR_ORDER;
      end
    end
    det      = (det_code != ERR_NONE);
    det_bits = err_bits(det_code);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_SYNC;
      phase_q    <= PH_NS_G;
      tick_cnt   <= '0;
      partial    <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      err_sticky <= '0;
      err_count  <= '0;
      rot_count  <= '0;
    end else begin
      err <= det;
      if (det)
        err_code <= det_code;
      // A same-cycle error survives the clear.
      if (clr_err) begin
        err_sticky <= det_bits;
        err_count  <= {{(ECW-1){1'b0}}, det};
      end else begin
        err_sticky <= err_sticky | det_bits;
        if (det && err_count != {ECW{1'b1}})
          err_count <= err_count + 1'b1;
      end

      unique case (state)
        ST_SYNC: begin
          // Lamps may be settling out of reset: ignore illegal here.
          if (dec_legal) begin
            state    <= ST_TRACK;
            locked   <= 1'b1;
            phase_q  <= dec_phase;
            tick_cnt <= '0;
            partial  <= 1'b1;
          end
        end
        ST_TRACK: begin
          if (!dec_legal) begin
            state  <= ST_SYNC;
            locked <= 1'b0;
          end else if (dec_phase == phase_q) begin
            if (tick && tick_cnt != n_cur + 1'b1)
              tick_cnt <= tick_cnt + 1'b1;
          end else begin
            // Successor or out-of-order jump: relock on the new phase.
            if (is_succ && phase_q == PH_EW_Y)
              rot_count <= rot_count + 1'b1;
            phase_q  <= dec_phase;
            tick_cnt <= {{(TW-1){1'b0}}, tick};
            partial  <= !is_succ;
          end
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor: vector table, directed
// multi-cycle sequences and random lamp traffic against a reference model.
module tb_traffic_light_monitor;

  localparam logic [5:0] L_NSG = 6'b100_001;
  localparam logic [5:0] L_NSY = 6'b010_001;
  localparam logic [5:0] L_EWG = 6'b001_100;
  localparam logic [5:0] L_EWY = 6'b001_010;
  localparam logic [5:0] L_BAD = 6'b100_100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        clr_err = 1'b0;
  logic [5:0]  lamps = 6'b000_000;
  logic [1:0]  phase;
  logic        locked;
  logic        err;
  logic [2:0]  err_code;
  logic [3:0]  err_sticky;
  logic [7:0]  err_count;
  logic [15:0] rot_count;

  int n_checks = 0;
  int n_fail   = 0;
  int err_pulses = 0;

  traffic_light_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .ns_g       (lamps[5]),
    .ns_y       (lamps[4]),
    .ns_r       (lamps[3]),
    .ew_g       (lamps[2]),
    .ew_y       (lamps[1]),
    .ew_r       (lamps[0]),
    .clr_err    (clr_err),
    .phase      (phase),
    .locked     (locked),
    .err        (err),
    .err_code   (err_code),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .rot_count  (rot_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: phase as an index into the rotation, an unbounded
  // tick count for the current phase, and error bookkeeping.
  int m_locked, m_phase, m_ticks, m_partial;
  int m_err, m_code, m_sticky, m_count, m_rot;

  function automatic int n_of(int p);
    case (p)
      0: return 5;
      1: return 2;
      2: return 5;
      default: return 2;
    endcase
  endfunction

  function automatic logic [5:0] lamp_of(int p);
    case (p)
      0: return L_NSG;
      1: return L_NSY;
      2: return L_EWG;
      default: return L_EWY;
    endcase
  endfunction

  task automatic m_reset();
    m_locked = 0; m_phase = 0; m_ticks = 0; m_partial = 0;
    m_err = 0; m_code = 0; m_sticky = 0; m_count = 0; m_rot = 0;
  endtask

  task automatic m_step();
    int nsc, ewc, ph, code, bitv;
    bit legal;
    nsc = int'(lamps[5]) + int'(lamps[4]) + int'(lamps[3]);
    ewc = int'(lamps[2]) + int'(lamps[1]) + int'(lamps[0]);
    legal = (nsc == 1) && (ewc == 1) && (lamps[3] != lamps[0]);
    if (lamps[0]) ph = lamps[5] ? 0 : 1;
    else          ph = lamps[2] ? 2 : 3;
    code = 0;
    if (m_locked == 0) begin
      if (legal) begin
        m_locked = 1; m_phase = ph; m_ticks = 0; m_partial = 1;
      end
    end else if (!legal) begin
      code = 1;
      m_locked = 0;
    end else if (ph == m_phase) begin
      if (tick) begin
        m_ticks++;
        if (m_partial == 0 && m_ticks == n_of(m_phase) + 1) code = 4;
      end
    end else if (ph == (m_phase + 1) % 4) begin
      if (m_partial == 0 && m_ticks < n_of(m_phase)) code = 3;
      if (m_phase == 3) m_rot = (m_rot + 1) % 65536;
      m_phase = ph; m_ticks = int'(tick); m_partial = 0;
    end else begin
      code = 2;
      m_phase = ph; m_ticks = int'(tick); m_partial = 1;
    end
    m_err = (code != 0) ? 1 : 0;
    if (code != 0) m_code = code;
    bitv = (code != 0) ? (1 << (code - 1)) : 0;
    if (clr_err) begin
      m_sticky = bitv;
      m_count  = (code != 0) ? 1 : 0;
    end else begin
      m_sticky = m_sticky | bitv;
      if (code != 0 && m_count < 255) m_count++;
    end
  endtask

  task automatic cyc();
    logic [63:0] expv;
    @(posedge clk);
    m_step();
    #1;
    if (err) err_pulses++;
    expv = {29'd0, 2'(m_phase), 1'(m_locked), 1'(m_err), 3'(m_code),
            4'(m_sticky), 8'(m_count), 16'(m_rot)};
    chk("model", {29'd0, phase, locked, err, err_code, err_sticky,
                  err_count, rot_count}, expv);
  endtask

  task automatic run_phase(input logic [5:0] l, input int n, input int per);
    lamps = l;
    repeat (n) begin
      tick = 1'b0;
      repeat (per - 1) cyc();
      tick = 1'b1;
      cyc();
    end
    tick = 1'b0;
  endtask

  task automatic rotation();
    run_phase(L_NSG, 5, 4);
    run_phase(L_NSY, 2, 4);
    run_phase(L_EWG, 5, 4);
    run_phase(L_EWY, 2, 4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [5:0] l;
    logic       t;
    logic [1:0] ph;
    logic       lk;
    logic       e;
    logic [2:0] code;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int ph, dur, per, r;
    logic [5:0] ill [4];

    tbl[0]  = '{6'b111_111, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0};
    tbl[1]  = '{L_NSY, 1'b1, 2'd1, 1'b1, 1'b0, 3'd0};
    tbl[2]  = '{L_NSY, 1'b1, 2'd1, 1'b1, 1'b0, 3'd0};
    tbl[3]  = '{L_EWG, 1'b0, 2'd2, 1'b1, 1'b0, 3'd0};
    for (int i = 4; i <= 8; i++)
      tbl[i] = '{L_EWG, 1'b1, 2'd2, 1'b1, 1'b0, 3'd0};
    tbl[9]  = '{L_EWY, 1'b1, 2'd3, 1'b1, 1'b0, 3'd0};
    tbl[10] = '{L_EWY, 1'b1, 2'd3, 1'b1, 1'b0, 3'd0};
    tbl[11] = '{L_NSG, 1'b0, 2'd0, 1'b1, 1'b0, 3'd0};
    tbl[12] = '{L_NSG, 1'b1, 2'd0, 1'b1, 1'b0, 3'd0};
    tbl[13] = '{L_EWY, 1'b0, 2'd3, 1'b1, 1'b1, 3'd2};
    tbl[14] = '{L_NSG, 1'b0, 2'd0, 1'b1, 1'b0, 3'd2};
    tbl[15] = '{6'b100_010, 1'b0, 2'd0, 1'b0, 1'b1, 3'd1};
    tbl[16] = '{L_NSG, 1'b0, 2'd0, 1'b1, 1'b0, 3'd1};

    ill[0] = L_BAD; ill[1] = 6'b000_000;
    ill[2] = 6'b101_001; ill[3] = 6'b010_010;

    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {phase, locked, err, err_code, err_sticky,
                        err_count, rot_count}, 64'd0);
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 17; i++) begin
      lamps = tbl[i].l;
      tick  = tbl[i].t;
      cyc();
      chk($sformatf("tbl%0d", i), {phase, locked, err, err_code},
          {tbl[i].ph, tbl[i].lk, tbl[i].e, tbl[i].code});
    end
    tick = 1'b0;

    // Three clean rotations
    lamps = L_NSG;
    do_reset();
    cyc();
    chk("lock_first_cycle", locked, 1'b1);
    err_pulses = 0;
    repeat (3) rotation();
    lamps = L_NSG;
    cyc();
    chk("clean_rot", rot_count, 16'd3);
    chk("clean_pulses", err_pulses, 0);
    chk("clean_sticky", err_sticky, 4'b0000);

    // Short NS green
    err_pulses = 0;
    run_phase(L_NSG, 4, 4);
    lamps = L_NSY;
    cyc();
    chk("short_err", err, 1'b1);
    chk("short_code", err_code, 3'd3);
    chk("short_sticky", err_sticky, 4'b0100);
    chk("short_count", err_count, 8'd1);
    run_phase(L_NSY, 2, 4);
    run_phase(L_EWG, 5, 4);
    run_phase(L_EWY, 2, 4);
    lamps = L_NSG;
    cyc();
    chk("short_pulses", err_pulses, 1);

    // Long NS green: 7 ticks
    err_pulses = 0;
    run_phase(L_NSG, 5, 4);
    chk("long_pre", err_pulses, 0);
    run_phase(L_NSG, 1, 4);
    chk("long_err", err, 1'b1);
    chk("long_code", err_code, 3'd4);
    run_phase(L_NSG, 1, 4);
    lamps = L_NSY;
    cyc();
    chk("long_no_short", err, 1'b0);
    chk("long_pulses", err_pulses, 1);
    run_phase(L_NSY, 2, 4);
    run_phase(L_EWG, 5, 4);
    run_phase(L_EWY, 2, 4);
    lamps = L_NSG;
    cyc();

    // Order jump, then partial phase, then short EW yellow
    run_phase(L_NSG, 5, 4);
    lamps = L_EWG;
    cyc();
    chk("order_err", err, 1'b1);
    chk("order_code", err_code, 3'd2);
    run_phase(L_EWG, 3, 4);
    lamps = L_EWY;
    cyc();
    chk("partial_ok", err, 1'b0);
    run_phase(L_EWY, 1, 4);
    lamps = L_NSG;
    cyc();
    chk("ewy_short_code", {err, err_code}, {1'b1, 3'd3});

    // Illegal lamps, relock, clear
    run_phase(L_NSG, 2, 4);
    lamps = L_BAD;
    cyc();
    chk("illegal", {err, err_code, locked}, {1'b1, 3'd1, 1'b0});
    lamps = L_NSG;
    cyc();
    chk("relock", locked, 1'b1);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    chk("clr", {err_sticky, err_count, err_code}, {4'b0000, 8'd0, 3'd1});
    lamps = L_EWY;
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    chk("clr_vs_err", {err_sticky, err_count}, {4'b0010, 8'd1});

    // Async reset mid EW green with count 5
    repeat (4) begin
      lamps = L_BAD;
      cyc();
      lamps = L_EWG;
      cyc();
    end
    run_phase(L_EWG, 2, 4);
    chk("count5", err_count, 8'd5);
    #3;
    rst = 1'b1;
    m_reset();
    #1;
    chk("reset_async", {phase, locked, err, err_code, err_sticky,
                        err_count, rot_count}, 64'd0);
    #1;
    rst = 1'b0;
    cyc();
    chk("relock_after_rst", {locked, phase}, {1'b1, 2'd2});

    // Error count saturation
    repeat (260) begin
      lamps = L_BAD;
      cyc();
      lamps = L_EWG;
      cyc();
    end
    chk("count_sat", err_count, 8'd255);

    // Random traffic against the model
    ph = 2;
    for (int s = 0; s < 200; s++) begin
      r = $urandom_range(0, 99);
      if (r < 5) begin
        lamps = ill[$urandom_range(0, 3)];
        tick = 1'($urandom_range(0, 1));
        clr_err = ($urandom_range(0, 19) == 0);
        cyc();
        clr_err = 1'b0;
        continue;
      end
      if (r < 13) ph = $urandom_range(0, 3);
      else        ph = (ph + 1) % 4;
      dur = n_of(ph) + $urandom_range(0, 2) - 1;
      per = $urandom_range(1, 4);
      lamps = lamp_of(ph);
      repeat (dur) begin
        for (int k = 0; k < per; k++) begin
          tick = (k == per - 1);
          clr_err = ($urandom_range(0, 39) == 0);
          cyc();
        end
      end
      tick = 1'b0;
      clr_err = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
